// File: rtl/exec_ctrl.sv
// rtl/exec_ctrl.sv - multi-cycle fetch/execute/writeback sequencer around an 8-entry register file
//
// Purpose:
//   Collects a 16-bit instruction as two bytes (low byte first), reads the
//   source registers, computes the ALU result, then spends one cycle
//   committing it to the register file.
//
// Instruction layout:
//   [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2, [5:0] imm6 (ADDI only)
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   byte_in, byte_valid        instruction byte stream (valid/ready)
//   byte_ready                 high while fetching (GET_LO / GET_HI)
//   rf_read_reg1/2             source register addresses (rs1/rs2)
//   rf_read_data1/2            combinational read data from the register file
//   rf_write_reg               destination register address (rd)
//   rf_we                      write enable, asserted for one cycle in WB
//   rf_write_data              registered ALU result
//   done                       one-cycle pulse when an instruction retires
//   illegal                    one-cycle pulse with done for an undefined op

module exec_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic [2:0]       rf_read_reg1,
  output logic [2:0]       rf_read_reg2,
  input  logic [WIDTH-1:0] rf_read_data1,
  input  logic [WIDTH-1:0] rf_read_data2,
  output logic [2:0]       rf_write_reg,
  output logic             rf_we,
  output logic [WIDTH-1:0] rf_write_data,
  output logic             done,
  output logic             illegal
);

  typedef enum logic [1:0] {
    GET_LO = 2'd0,
    GET_HI = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;

  state_t            state;
  state_t            state_nxt;
  logic [15:0]       instr;
  logic [3:0]        op;
  logic [5:0]        imm6;
  logic              op_illegal;
  logic              accept;
  logic [WIDTH-1:0]  imm_ext;
  logic [WIDTH-1:0]  alu_result;

  // Fields are decoded straight from the instruction register, so the
  // addresses stay stable from EXEC through WB without extra staging.
  assign op           = instr[15:12];
  assign rf_write_reg = instr[11:9];
  assign rf_read_reg1 = instr[8:6];
  assign rf_read_reg2 = instr[5:3];
  assign imm6         = instr[5:0];
  assign op_illegal   = (op > OP_ADDI);
  assign imm_ext      = {{(WIDTH-6){imm6[5]}}, imm6};

  assign accept = byte_valid && byte_ready;

  always_comb begin
    alu_result = '0;
    unique case (op)
      OP_ADD:  alu_result = rf_read_data1 + rf_read_data2;
      OP_SUB:  alu_result = rf_read_data1 - rf_read_data2;
      OP_AND:  alu_result = rf_read_data1 & rf_read_data2;
      OP_OR:   alu_result = rf_read_data1 | rf_read_data2;
      OP_XOR:  alu_result = rf_read_data1 ^ rf_read_data2;
      OP_SLT:  alu_result = {{(WIDTH-1){1'b0}},
                             ($signed(rf_read_data1) < $signed(rf_read_data2))};
      OP_ADDI: alu_result = rf_read_data1 + imm_ext;
      default: alu_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= GET_LO;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs decode from state alone, so an asynchronous reset drops
  // rf_we/done/illegal immediately.
  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    rf_we      = 1'b0;
    done       = 1'b0;
    illegal    = 1'b0;
    unique case (state)
      GET_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nxt = GET_HI;
      end
      GET_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nxt = EXEC;
      end
      EXEC: begin
        state_nxt = WB;
      end
      WB: begin
        rf_we     = !op_illegal && (rf_write_reg != 3'd0);
        done      = 1'b1;
        illegal   = op_illegal;
        state_nxt = GET_LO;
      end
      default: state_nxt = GET_LO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr         <= '0;
      rf_write_data <= '0;
    end else begin
      if (accept && state == GET_LO) instr[7:0]  <= byte_in;
      if (accept && state == GET_HI) instr[15:8] <= byte_in;
      if (state == EXEC)             rf_write_data <= alu_result;
    end
  end

endmodule

// File: tb/tb_exec_ctrl.sv
// tb/tb_exec_ctrl.sv - table-driven directed bench for exec_ctrl
//
// Purpose:
//   Applies a table of instructions with fixed register read data and checks
//   decode, ALU result, write enable and retire pulses at each stage, then
//   runs a streaming sequence and reset corner cases.
//
// Ports: none (top-level bench).

module tb_exec_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic [2:0] rf_read_reg1;
  logic [2:0] rf_read_reg2;
  logic [7:0] rf_read_data1;
  logic [7:0] rf_read_data2;
  logic [2:0] rf_write_reg;
  logic       rf_we;
  logic [7:0] rf_write_data;
  logic       done;
  logic       illegal;

  int vec_cnt = 0;
  int err_cnt = 0;

  exec_ctrl #(.WIDTH(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .rf_read_reg1  (rf_read_reg1),
    .rf_read_reg2  (rf_read_reg2),
    .rf_read_data1 (rf_read_data1),
    .rf_read_data2 (rf_read_data2),
    .rf_write_reg  (rf_write_reg),
    .rf_we         (rf_we),
    .rf_write_data (rf_write_data),
    .done          (done),
    .illegal       (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  d1;
    logic [7:0]  d2;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [2:0]  rd;
    logic [7:0]  result;
    logic        we;
    logic        ill;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one byte and return just after the edge on which it was accepted.
  task automatic send_byte(input logic [7:0] b);
    bit sent = 0;
    for (int i = 0; i < 20 && !sent; i++) begin
      @(negedge clk);
      if (byte_ready) begin
        byte_in    = b;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        sent = 1;
      end
    end
    if (!sent) chk("send_byte_timeout", 16'd0, 16'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    rf_read_data1 = v.d1;
    rf_read_data2 = v.d2;
    send_byte(v.instr[7:0]);
    send_byte(v.instr[15:8]);
    @(negedge clk);
    chk({tag, "_exec_ready"}, 16'(byte_ready), 16'd0);
    chk({tag, "_exec_we"}, 16'(rf_we), 16'd0);
    chk({tag, "_rs1"}, 16'(rf_read_reg1), 16'(v.rs1));
    chk({tag, "_rs2"}, 16'(rf_read_reg2), 16'(v.rs2));
    @(negedge clk);
    chk({tag, "_wb_ready"}, 16'(byte_ready), 16'd0);
    chk({tag, "_we"}, 16'(rf_we), 16'(v.we));
    chk({tag, "_done"}, 16'(done), 16'd1);
    chk({tag, "_illegal"}, 16'(illegal), 16'(v.ill));
    chk({tag, "_rd"}, 16'(rf_write_reg), 16'(v.rd));
    if (v.we) chk({tag, "_data"}, 16'(rf_write_data), 16'(v.result));
    @(negedge clk);
    chk({tag, "_idle_ready"}, 16'(byte_ready), 16'd1);
    chk({tag, "_idle_done"}, 16'(done), 16'd0);
  endtask

  initial begin
    vec_t r;
    logic [7:0]  stream [6];
    logic [2:0]  s_rd   [3];
    logic [7:0]  s_res  [3];
    int idx;
    int retired;
    bit rdy;

    //               instr     d1     d2     rs1   rs2   rd    result we   ill
    vecs[0] = '{16'h62BD, 8'h10, 8'h00, 3'd2, 3'd7, 3'd1, 8'h0D, 1'b1, 1'b0}; // ADDI x1,x2,-3
    vecs[1] = '{16'h0650, 8'hF0, 8'h20, 3'd1, 3'd2, 3'd3, 8'h10, 1'b1, 1'b0}; // ADD wrap
    vecs[2] = '{16'h1650, 8'h00, 8'h01, 3'd1, 3'd2, 3'd3, 8'hFF, 1'b1, 1'b0}; // SUB wrap
    vecs[3] = '{16'h5850, 8'h80, 8'h01, 3'd1, 3'd2, 3'd4, 8'h01, 1'b1, 1'b0}; // SLT -128<1
    vecs[4] = '{16'h5850, 8'h01, 8'h80, 3'd1, 3'd2, 3'd4, 8'h00, 1'b1, 1'b0}; // SLT 1<-128
    vecs[5] = '{16'h0050, 8'h11, 8'h22, 3'd1, 3'd2, 3'd0, 8'h33, 1'b0, 1'b0}; // ADD x0
    vecs[6] = '{16'hF000, 8'h11, 8'h22, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 1'b1}; // illegal
    vecs[7] = '{16'h2C50, 8'h05, 8'h03, 3'd1, 3'd2, 3'd6, 8'h01, 1'b1, 1'b0}; // AND
    vecs[8] = '{16'h3E50, 8'h05, 8'h03, 3'd1, 3'd2, 3'd7, 8'h07, 1'b1, 1'b0}; // OR
    vecs[9] = '{16'h64C5, 8'hFE, 8'h00, 3'd3, 3'd0, 3'd2, 8'h03, 1'b1, 1'b0}; // ADDI +5 wrap

    rst_n         = 1'b0;
    byte_in       = 8'h00;
    byte_valid    = 1'b0;
    rf_read_data1 = 8'h00;
    rf_read_data2 = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_ready", 16'(byte_ready), 16'd1);
    chk("rst_we", 16'(rf_we), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_illegal", 16'(illegal), 16'd0);
    chk("rst_wdata", 16'(rf_write_data), 16'd0);
    chk("rst_addr", {7'd0, rf_read_reg1, rf_read_reg2, rf_write_reg}, 16'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Streaming: valid held high, ADD x1 / SUB x2 / XOR x5 with d1=5, d2=3.
    stream = '{8'h50, 8'h02, 8'h50, 8'h14, 8'h50, 8'h4A};
    s_rd   = '{3'd1, 3'd2, 3'd5};
    s_res  = '{8'h08, 8'h02, 8'h06};
    rf_read_data1 = 8'h05;
    rf_read_data2 = 8'h03;
    idx = 0;
    retired = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("st_ready_c%0d", c), 16'(byte_ready), 16'((c % 4) < 2));
      chk($sformatf("st_done_c%0d", c), 16'(done), 16'((c % 4) == 3));
      if (done && retired < 3) begin
        chk($sformatf("st_rd%0d", retired), 16'(rf_write_reg), 16'(s_rd[retired]));
        chk($sformatf("st_data%0d", retired), 16'(rf_write_data), 16'(s_res[retired]));
        chk($sformatf("st_we%0d", retired), 16'(rf_we), 16'd1);
        retired++;
      end
      rdy = byte_ready;
      if (idx < 6) begin
        byte_in    = stream[idx];
        byte_valid = 1'b1;
      end else begin
        byte_valid = 1'b0;
      end
      @(posedge clk);
      if (rdy && idx < 6) idx++;
    end
    byte_valid = 1'b0;
    chk("st_retired", 16'(retired), 16'd3);
    chk("st_consumed", 16'(idx), 16'd6);

    // Partial instruction discarded by reset.
    @(negedge clk);
    send_byte(8'h50);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 16'(byte_ready), 16'd1);
    chk("mid_rst_addr", {7'd0, rf_read_reg1, rf_read_reg2, rf_write_reg}, 16'd0);
    chk("mid_rst_done", 16'(done), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    r = '{16'h0650, 8'h0F, 8'h01, 3'd1, 3'd2, 3'd3, 8'h10, 1'b1, 1'b0};
    run_vec(r, "post_rst");

    // Reset during WB drops rf_we/done immediately.
    rf_read_data1 = 8'h01;
    rf_read_data2 = 8'h01;
    send_byte(8'h50);
    send_byte(8'h06);
    @(negedge clk);
    @(negedge clk);
    chk("wb_pre_we", 16'(rf_we), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("wb_rst_we", 16'(rf_we), 16'd0);
    chk("wb_rst_done", 16'(done), 16'd0);
    chk("wb_rst_wdata", 16'(rf_write_data), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
